mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  Elastic MEM->WB boundary. Accepts retiring results from the memory stage over a valid/ready handshake.
//  Selects the write-back value (memory load data or ALU result) at capture and buffers up to 2 entries.
//  Presents the head entry to the register-file write port. Also drives a forwarding tap and a retired-instruction counter.
// PARAMETERS
//  DATA_W  32  width of ALU result, load data and write-back value
//  DST_W   4   destination register index width
//  CNT_W   32  retired-instruction counter width
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       synchronous, active-low reset (sampled on clk rising edge)
//  in_valid   in   1       MEM stage presents a result
//  in_ready   out  1       stage can accept this cycle (registered)
//  dst        in   DST_W   destination register from MEM stage
//  alu_res    in   DATA_W  ALU result from MEM stage
//  mem_out    in   DATA_W  load data from MEM stage
//  mem_read   in   1       1: write back mem_out, 0: write back alu_res
//  wb_en      in   1       instruction writes a register
//  freeze     in   1       global stall: no push, no pop
//  flush      in   1       discard all buffered entries
//  rf_ready   in   1       register-file write port accepts this cycle
//  out_valid  out  1       head entry present
//  wb_we      out  1       register write strobe = out_valid & rf_ready & ~freeze & head.wb_en
//  wb_dst     out  DST_W   head destination
//  wb_value   out  DATA_W  head write-back value
//  fwd_en     out  1       out_valid & head.wb_en (hazard unit forwarding tap)
//  retired    out  CNT_W   count of entries popped since reset
// BEHAVIOUR
//  - Reset (rst==0 at edge): state=EMPTY, in_ready=0, out_valid=0, wb_we=0, wb_dst=0, wb_value=0, fwd_en=0, retired=0.
//    in_ready rises on the first edge with rst==1.
//  - push = in_valid & in_ready & ~freeze & ~flush.
//  - pop = out_valid & rf_ready & ~freeze & ~flush.
//  - Captured entry = {dst, mem_read ? mem_out : alu_res, wb_en}. Value is selected at capture; mem_read is not stored.
//  - Entries with wb_en=0 still occupy a slot and still pop, so they count in retired; they assert no wb_we.
//  - FSM (entry count):
//      EMPTY: push -> ONE
//      ONE:   push & ~pop -> FULL; pop & ~push -> EMPTY; push & pop -> ONE (head replaced by incoming)
//      FULL:  pop -> ONE (tail becomes head); no push possible
//  - in_ready registered = (next_state != FULL) & rst; it is not gated by freeze, which gates push instead.
//  - Ordering is strict FIFO. Head is always slot 0; on pop in FULL, slot1 moves to slot0.
//  - Latency: an entry pushed at edge N is visible on wb_* after edge N (1 cycle). Throughput is 1/cycle when rf_ready is held 1.
//  - flush: next state EMPTY, retired unchanged, incoming entry dropped, in_ready=1 next cycle.
//    flush has priority over push, pop and freeze.
//  - freeze: state, entries and retired hold. wb_we is forced 0. out_valid and fwd_en still reflect the head.
//  - retired increments by 1 on each pop and wraps modulo 2^CNT_W with no saturation.
//  - Outputs wb_dst/wb_value hold their last head values while out_valid=0. The value is don't-care but must not be X after reset.
// STRUCTURE
//  - Shared package arch_pkg:
//      typedef wb_entry_t {dst[DST_W], value[DATA_W], wb_en}
//      localparam FSM encodings EMPTY=2'd0, ONE=2'd1, FULL=2'd2
//  - Sub-module wb_fifo2: the 2-slot storage and FSM with push/pop/flush ports.
//  - Top level holds the capture mux, the wb_we/fwd_en gating and the retired counter.
// TESTING
//  1. Reset: hold rst=0 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, retired=0. First edge after release -> in_ready=1.
//  2. Streaming: rf_ready=1; push dst=3 alu_res=0x11 mem_read=0 wb_en=1, then dst=5 mem_out=0xAB mem_read=1 on consecutive cycles
//     -> wb_we on cycles +1 and +2 with (3,0x11) then (5,0xAB); retired=2.
//  3. Backpressure: rf_ready=0, push 3 entries A,B,C -> in_ready=0 after B, C held at input.
//     Raise rf_ready -> A, B, C written in order; no entry lost or duplicated.
//  4. Simultaneous push+pop in ONE: state stays ONE, head becomes the new entry next cycle; retired+1.
//  5. Flush with FULL and in_valid=1 -> next cycle out_valid=0, in_ready=1, wb_we=0, retired unchanged. The incoming entry is not written.
//  6. Freeze with FULL and rf_ready=1 for 4 cycles -> wb_we=0 and entries/retired unchanged. Release -> both entries pop in order.
//     Also: retired preloaded to 2^CNT_W-1, one pop -> retired=0.

Source files
------------

// File: rtl/arch_pkg.sv
// Shared definitions for the MEM->WB boundary: buffered entry layout and
// the occupancy encoding used by the two-slot write-back buffer.
package arch_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_DST_W  = 4;

   // One buffered write-back entry. The write-back value is already selected
   // (load data or ALU result) when the entry is captured.
   typedef struct packed {
      logic [WB_DST_W-1:0]  dst;
      logic [WB_DATA_W-1:0] value;
      logic                 wb_en;
   } wb_entry_t;

   localparam int WB_ENTRY_W = $bits(wb_entry_t);

   // Occupancy of the two-slot buffer.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } fifo_state_t;

   // True when the given occupancy leaves room for another entry.
   function automatic logic has_room(input fifo_state_t st);
      return (st != FULL);
   endfunction

endpackage

// File: rtl/wb_fifo2.sv
// Two-slot strict-FIFO write-back buffer. Slot 0 is always the head; the
// occupancy FSM decides where an incoming entry lands and when the tail
// moves up. Flush empties the buffer and wins over push and pop.
module wb_fifo2
   import arch_pkg::*;
#(
   parameter int ENT_W = WB_ENTRY_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  logic [ENT_W-1:0] i_entry,
   output logic             o_in_ready,
   output logic             o_out_valid,
   output logic [ENT_W-1:0] o_head
);

   fifo_state_t      r_state;
   fifo_state_t      w_next;
   logic [ENT_W-1:0] r_slot0;
   logic [ENT_W-1:0] r_slot1;
   logic             r_in_ready;

   // Next occupancy from push/pop; flush always returns to EMPTY.
   always_comb begin
      w_next = r_state;
      if (i_flush) begin
         w_next = EMPTY;
      end else begin
         case (r_state)
            EMPTY: begin
               if (i_push) w_next = ONE;
            end
            ONE: begin
               if (i_push && !i_pop)      w_next = FULL;
               else if (i_pop && !i_push) w_next = EMPTY;
            end
            FULL: begin
               if (i_pop) w_next = ONE;
            end
            default: w_next = EMPTY;
         endcase
      end
   end

   // Occupancy register and registered ready (low while in reset).
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= EMPTY;
         r_in_ready <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_in_ready <= has_room(w_next);
      end
   end

   // Slot storage: cleared in reset so the head outputs are never X; holds
   // its contents on flush, which keeps the last head visible while empty.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_slot0 <= '0;
         r_slot1 <= '0;
      end else if (!i_flush) begin
         case (r_state)
            EMPTY: begin
               if (i_push) r_slot0 <= i_entry;
            end
            ONE: begin
               if (i_push && i_pop) r_slot0 <= i_entry;
               else if (i_push)     r_slot1 <= i_entry;
            end
            FULL: begin
               if (i_pop) r_slot0 <= r_slot1;
            end
            default: begin
               r_slot0 <= r_slot0;
            end
         endcase
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_out_valid = (r_state != EMPTY);
   assign o_head      = r_slot0;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB elastic boundary: selects the write-back value at capture,
// buffers up to two entries, drives the register-file write port, the
// forwarding tap and a free-running retired-instruction counter.
module mem_wb_stage
   import arch_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DST_W  = 4,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DST_W-1:0]  dst,
   input  logic [DATA_W-1:0] alu_res,
   input  logic [DATA_W-1:0] mem_out,
   input  logic              mem_read,
   input  logic              wb_en,
   input  logic              freeze,
   input  logic              flush,
   input  logic              rf_ready,
   output logic              out_valid,
   output logic              wb_we,
   output logic [DST_W-1:0]  wb_dst,
   output logic [DATA_W-1:0] wb_value,
   output logic              fwd_en,
   output logic [CNT_W-1:0]  retired
);

   localparam int ENT_W = DST_W + DATA_W + 1;

   logic [ENT_W-1:0] w_entry;
   logic [ENT_W-1:0] w_head;
   logic             w_in_ready;
   logic             w_out_valid;
   logic             w_push;
   logic             w_pop;
   logic             w_head_wb_en;
   logic [CNT_W-1:0] r_retired;

   // Entry layout matches wb_entry_t: {dst, value, wb_en}. mem_read only
   // steers the value mux and is not kept.
   assign w_entry = {dst, (mem_read ? mem_out : alu_res), wb_en};

   // Freeze blocks both directions; flush overrides everything.
   assign w_push = in_valid & w_in_ready & ~freeze & ~flush;
   assign w_pop  = w_out_valid & rf_ready & ~freeze & ~flush;

   wb_fifo2 #(
      .ENT_W (ENT_W)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_pop       (w_pop),
      .i_flush     (flush),
      .i_entry     (w_entry),
      .o_in_ready  (w_in_ready),
      .o_out_valid (w_out_valid),
      .o_head      (w_head)
   );

   assign w_head_wb_en = w_head[0];

   // Retired counter: one per popped entry, including non-writing ones;
   // wraps naturally.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_retired <= '0;
      end else if (w_pop) begin
         r_retired <= r_retired + 1'b1;
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = w_out_valid;
   assign wb_we     = w_out_valid & rf_ready & ~freeze & w_head_wb_en;
   assign fwd_en    = w_out_valid & w_head_wb_en;
   assign wb_dst    = w_head[ENT_W-1 -: DST_W];
   assign wb_value  = w_head[DATA_W:1];
   assign retired   = r_retired;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vector table followed by randomized
// traffic checked against a queue-based model of the buffer.
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [3:0]  dst;
   logic [31:0] alu_res;
   logic [31:0] mem_out;
   logic        mem_read;
   logic        wb_en;
   logic        freeze;
   logic        flush;
   logic        rf_ready;

   logic        in_ready, out_valid, wb_we, fwd_en;
   logic [3:0]  wb_dst;
   logic [31:0] wb_value;
   logic [31:0] retired;

   logic        in_ready_n, out_valid_n, wb_we_n, fwd_en_n;
   logic [3:0]  wb_dst_n;
   logic [31:0] wb_value_n;
   logic [2:0]  retired_n;

   always #5 clk = ~clk;

   mem_wb_stage #(.DATA_W(32), .DST_W(4), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .dst(dst), .alu_res(alu_res), .mem_out(mem_out), .mem_read(mem_read),
      .wb_en(wb_en), .freeze(freeze), .flush(flush), .rf_ready(rf_ready),
      .out_valid(out_valid), .wb_we(wb_we), .wb_dst(wb_dst),
      .wb_value(wb_value), .fwd_en(fwd_en), .retired(retired)
   );

   // Narrow counter instance, driven identically, to exercise wraparound.
   mem_wb_stage #(.DATA_W(32), .DST_W(4), .CNT_W(3)) dut_n (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n),
      .dst(dst), .alu_res(alu_res), .mem_out(mem_out), .mem_read(mem_read),
      .wb_en(wb_en), .freeze(freeze), .flush(flush), .rf_ready(rf_ready),
      .out_valid(out_valid_n), .wb_we(wb_we_n), .wb_dst(wb_dst_n),
      .wb_value(wb_value_n), .fwd_en(fwd_en_n), .retired(retired_n)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input logic e_rdy, input logic e_ov, input logic e_we,
                            input logic e_fwd, input logic [3:0] e_dst,
                            input logic [31:0] e_val, input logic [31:0] e_ret);
      chk("in_ready",   {63'd0, in_ready},  {63'd0, e_rdy});
      chk("out_valid",  {63'd0, out_valid}, {63'd0, e_ov});
      chk("wb_we",      {63'd0, wb_we},     {63'd0, e_we});
      chk("fwd_en",     {63'd0, fwd_en},    {63'd0, e_fwd});
      chk("wb_dst",     {60'd0, wb_dst},    {60'd0, e_dst});
      chk("wb_value",   {32'd0, wb_value},  {32'd0, e_val});
      chk("retired",    {32'd0, retired},   {32'd0, e_ret});
      chk("n_in_ready", {63'd0, in_ready_n},  {63'd0, e_rdy});
      chk("n_out_valid",{63'd0, out_valid_n}, {63'd0, e_ov});
      chk("n_wb_we",    {63'd0, wb_we_n},     {63'd0, e_we});
      chk("n_fwd_en",   {63'd0, fwd_en_n},    {63'd0, e_fwd});
      chk("n_wb_dst",   {60'd0, wb_dst_n},    {60'd0, e_dst});
      chk("n_wb_value", {32'd0, wb_value_n},  {32'd0, e_val});
      chk("n_retired",  {61'd0, retired_n},   {61'd0, e_ret[2:0]});
   endtask

   // One directed row: inputs held across an edge, outputs expected just after it.
   typedef struct {
      logic        rst, iv;
      logic [3:0]  dst;
      logic [31:0] alu, mem;
      logic        mr, wen, frz, fl, rf;
      logic        e_rdy, e_ov, e_we, e_fwd;
      logic [3:0]  e_dst;
      logic [31:0] e_val;
      logic [31:0] e_ret;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic r, input logic iv, input logic [3:0] d, input logic [31:0] a,
      input logic [31:0] m, input logic mr, input logic we, input logic fz,
      input logic fl, input logic rf, input logic e_rdy, input logic e_ov,
      input logic e_we, input logic e_fwd, input logic [3:0] e_dst,
      input logic [31:0] e_val, input logic [31:0] e_ret);
      vec_t v;
      v.rst = r; v.iv = iv; v.dst = d; v.alu = a; v.mem = m; v.mr = mr;
      v.wen = we; v.frz = fz; v.fl = fl; v.rf = rf;
      v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_we = e_we; v.e_fwd = e_fwd;
      v.e_dst = e_dst; v.e_val = e_val; v.e_ret = e_ret;
      return v;
   endfunction

   // Model of the buffer for randomized traffic.
   typedef struct {
      logic [3:0]  dst;
      logic [31:0] val;
      logic        wen;
   } ent_t;

   ent_t        mq[$];
   ent_t        m_last;
   ent_t        m_new;
   logic        m_rdy;
   logic [31:0] m_ret;
   logic        m_push, m_pop;

   initial begin
      rst = 1'b0; in_valid = 1'b0; dst = '0; alu_res = '0; mem_out = '0;
      mem_read = 1'b0; wb_en = 1'b0; freeze = 1'b0; flush = 1'b0; rf_ready = 1'b0;

      //            rst iv dst    alu     mem     mr we fz fl rf   rdy ov we fwd dst    val     ret
      // reset held three cycles with in_valid high
      vecs.push_back(mk(0, 1, 4'h1, 32'h99, 32'h0,  0, 1, 0, 0, 0,  0, 0, 0, 0, 4'h0, 32'h0,  0));
      vecs.push_back(mk(0, 1, 4'h1, 32'h99, 32'h0,  0, 1, 0, 0, 0,  0, 0, 0, 0, 4'h0, 32'h0,  0));
      vecs.push_back(mk(0, 1, 4'h1, 32'h99, 32'h0,  0, 1, 0, 0, 0,  0, 0, 0, 0, 4'h0, 32'h0,  0));
      vecs.push_back(mk(1, 0, 4'h0, 32'h0,  32'h0,  0, 0, 0, 0, 1,  1, 0, 0, 0, 4'h0, 32'h0,  0));
      // streaming: ALU result then load data; second push pops the first
      vecs.push_back(mk(1, 1, 4'h3, 32'h11, 32'h77, 0, 1, 0, 0, 1,  1, 1, 1, 1, 4'h3, 32'h11, 0));
      vecs.push_back(mk(1, 1, 4'h5, 32'h22, 32'hAB, 1, 1, 0, 0, 1,  1, 1, 1, 1, 4'h5, 32'hAB, 1));
      vecs.push_back(mk(1, 0, 4'h0, 32'h0,  32'h0,  0, 0, 0, 0, 1,  1, 0, 0, 0, 4'h5, 32'hAB, 2));
      // fill to FULL, then flush with a valid incoming entry
      vecs.push_back(mk(1, 1, 4'h7, 32'h70, 32'h0,  0, 1, 0, 0, 0,  1, 1, 0, 1, 4'h7, 32'h70, 2));
      vecs.push_back(mk(1, 1, 4'h8, 32'h80, 32'h0,  0, 0, 0, 0, 0,  0, 1, 0, 1, 4'h7, 32'h70, 2));
      vecs.push_back(mk(1, 1, 4'h9, 32'h90, 32'h0,  0, 1, 0, 1, 0,  1, 0, 0, 0, 4'h7, 32'h70, 2));
      vecs.push_back(mk(1, 0, 4'h0, 32'h0,  32'h0,  0, 0, 0, 0, 1,  1, 0, 0, 0, 4'h7, 32'h70, 2));
      // entry without register write still occupies a slot and retires
      vecs.push_back(mk(1, 1, 4'hA, 32'hA0, 32'h0,  0, 0, 0, 0, 1,  1, 1, 0, 0, 4'hA, 32'hA0, 2));
      vecs.push_back(mk(1, 0, 4'h0, 32'h0,  32'h0,  0, 0, 0, 0, 1,  1, 0, 0, 0, 4'hA, 32'hA0, 3));
      // FULL then freeze four cycles with rf_ready high, then drain
      vecs.push_back(mk(1, 1, 4'h2, 32'h21, 32'h0,  0, 1, 0, 0, 0,  1, 1, 0, 1, 4'h2, 32'h21, 3));
      vecs.push_back(mk(1, 1, 4'h4, 32'h0,  32'h41, 1, 1, 0, 0, 0,  0, 1, 0, 1, 4'h2, 32'h21, 3));
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(1, 1, 4'h6, 32'h61, 32'h0, 0, 1, 1, 0, 1, 0, 1, 0, 1, 4'h2, 32'h21, 3));
      vecs.push_back(mk(1, 0, 4'h0, 32'h0,  32'h0,  0, 0, 0, 0, 1,  1, 1, 1, 1, 4'h4, 32'h41, 4));
      vecs.push_back(mk(1, 0, 4'h0, 32'h0,  32'h0,  0, 0, 0, 0, 1,  1, 0, 0, 0, 4'h4, 32'h41, 5));
      // backpressure: A, B accepted, C held at input, then drained in order
      vecs.push_back(mk(1, 1, 4'hB, 32'hB1, 32'h0,  0, 1, 0, 0, 0,  1, 1, 0, 1, 4'hB, 32'hB1, 5));
      vecs.push_back(mk(1, 1, 4'hC, 32'hC1, 32'h0,  0, 1, 0, 0, 0,  0, 1, 0, 1, 4'hB, 32'hB1, 5));
      vecs.push_back(mk(1, 1, 4'hD, 32'hD1, 32'h0,  0, 1, 0, 0, 0,  0, 1, 0, 1, 4'hB, 32'hB1, 5));
      vecs.push_back(mk(1, 1, 4'hD, 32'hD1, 32'h0,  0, 1, 0, 0, 1,  1, 1, 1, 1, 4'hC, 32'hC1, 6));
      vecs.push_back(mk(1, 1, 4'hD, 32'hD1, 32'h0,  0, 1, 0, 0, 1,  1, 1, 1, 1, 4'hD, 32'hD1, 7));
      // eighth pop: narrow counter wraps 7 -> 0
      vecs.push_back(mk(1, 0, 4'h0, 32'h0,  32'h0,  0, 0, 0, 0, 1,  1, 0, 0, 0, 4'hD, 32'hD1, 8));

      @(posedge clk); #1;
      foreach (vecs[i]) begin
         rst = vecs[i].rst; in_valid = vecs[i].iv; dst = vecs[i].dst;
         alu_res = vecs[i].alu; mem_out = vecs[i].mem; mem_read = vecs[i].mr;
         wb_en = vecs[i].wen; freeze = vecs[i].frz; flush = vecs[i].fl;
         rf_ready = vecs[i].rf;
         @(posedge clk); #1;
         check_all(vecs[i].e_rdy, vecs[i].e_ov, vecs[i].e_we, vecs[i].e_fwd,
                   vecs[i].e_dst, vecs[i].e_val, vecs[i].e_ret);
      end

      // Randomized traffic against the queue model; starts with a reset cycle.
      for (int c = 0; c < 4000; c++) begin
         rst      = (c == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
         in_valid = ($urandom_range(0, 3) != 0);
         dst      = 4'($urandom);
         alu_res  = $urandom;
         mem_out  = $urandom;
         mem_read = 1'($urandom);
         wb_en    = ($urandom_range(0, 4) != 0);
         freeze   = ($urandom_range(0, 7) == 0);
         flush    = ($urandom_range(0, 19) == 0);
         rf_ready = ($urandom_range(0, 9) < 6);

         if (!rst) begin
            mq.delete();
            m_ret  = '0;
            m_rdy  = 1'b0;
            m_last = '{dst: 4'h0, val: 32'h0, wen: 1'b0};
         end else begin
            m_push = in_valid && m_rdy && !freeze && !flush;
            m_pop  = (mq.size() != 0) && rf_ready && !freeze && !flush;
            m_new  = '{dst: dst, val: (mem_read ? mem_out : alu_res), wen: wb_en};
            if (flush) begin
               mq.delete();
            end else begin
               if (m_pop) begin
                  void'(mq.pop_front());
                  m_ret = m_ret + 32'd1;
               end
               if (m_push) mq.push_back(m_new);
            end
            m_rdy = (mq.size() < 2);
         end
         if (mq.size() != 0) m_last = mq[0];

         @(posedge clk); #1;
         check_all(m_rdy, (mq.size() != 0),
                   (mq.size() != 0) && rf_ready && !freeze && m_last.wen,
                   (mq.size() != 0) && m_last.wen,
                   m_last.dst, m_last.val, m_ret);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
